// File: rtl/midi_encoder.sv
// MIDI channel-voice event serialiser with running status, timed refresh and optional note-off->vel0.
// Latency: first byte valid the cycle after ev_valid&&ev_ready; one byte per tx_valid&&tx_ready.
// Backpressure: tx_ready low freezes state and tx_byte; ev_ready is high only while idle.
module midi_encoder #(
  parameter bit          RS_EN           = 1'b1,
  parameter int unsigned RS_TIMEOUT      = 6250000,
  parameter bit          NOTEOFF_AS_VEL0 = 1'b0,
  parameter int          T_WIDTH         = 23
) (
  input  logic       CLOCK_25,
  input  logic       iRST,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [2:0] ev_type,
  input  logic [3:0] ev_chan,
  input  logic [7:0] ev_d1,
  input  logic [7:0] ev_d2,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       ev_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;

  localparam logic [T_WIDTH-1:0] TMAX = T_WIDTH'(RS_TIMEOUT);

  state_t             state, state_nxt;
  logic [7:0]         st_q, d1_q, d2_q;
  logic               two_q;
  logic [7:0]         last_status;
  logic [T_WIDTH-1:0] timer;

  logic [3:0] hi;
  logic [7:0] st_in, d1_in, d2_in;
  logic       ev_ok, two_in, accept, rs_live, skip_status, status_xfer;

  // Map the incoming event onto status/data bytes before it is latched.
  always_comb begin
    hi     = 4'h0;
    ev_ok  = 1'b1;
    two_in = 1'b1;
    d1_in  = ev_d1 & 8'h7F;
    d2_in  = ev_d2 & 8'h7F;
    case (ev_type)
      3'd0: begin
        hi = NOTEOFF_AS_VEL0 ? 4'h9 : 4'h8;
        if (NOTEOFF_AS_VEL0) d2_in = 8'h00;
      end
      3'd1: hi = 4'h9;
      3'd2: hi = 4'hB;
      3'd3: begin
        hi     = 4'hC;
        two_in = 1'b0;
      end
      3'd4: hi = 4'hE;
      3'd5: begin
        hi    = 4'hB;
        d1_in = 8'h7B;
        d2_in = 8'h00;
      end
      default: ev_ok = 1'b0;
    endcase
  end

  assign st_in       = {hi, ev_chan};
  assign accept      = ev_valid && (state == IDLE);
  // A saturated timer means running status has already expired this cycle.
  assign rs_live     = (RS_TIMEOUT == 0) || (timer != TMAX);
  assign skip_status = RS_EN && rs_live && (st_in == last_status);
  assign status_xfer = (state == STATUS) && tx_ready;
  assign ev_ready    = (state == IDLE);
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    case (state)
      IDLE: begin
        if (accept && ev_ok) state_nxt = skip_status ? DATA1 : STATUS;
      end
      STATUS: begin
        tx_valid = 1'b1;
        tx_byte  = st_q;
        if (tx_ready) state_nxt = DATA1;
      end
      DATA1: begin
        tx_valid = 1'b1;
        tx_byte  = d1_q;
        if (tx_ready) state_nxt = two_q ? DATA2 : IDLE;
      end
      DATA2: begin
        tx_valid = 1'b1;
        tx_byte  = d2_q;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      state       <= IDLE;
      st_q        <= 8'h00;
      d1_q        <= 8'h00;
      d2_q        <= 8'h00;
      two_q       <= 1'b0;
      last_status <= 8'h00;
      timer       <= '0;
      ev_err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      ev_err <= accept && !ev_ok;
      if (accept && ev_ok) begin
        st_q  <= st_in;
        d1_q  <= d1_in;
        d2_q  <= d2_in;
        two_q <= two_in;
      end
      if (status_xfer) begin
        last_status <= st_q;
        timer       <= '0;
      end else begin
        if (timer != TMAX) timer <= timer + T_WIDTH'(1);
        if ((RS_TIMEOUT != 0) && (timer == TMAX)) last_status <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_midi_encoder.sv
// Bench for midi_encoder: three parameter sets, directed sequences plus random events vs a byte-queue model.
module tb_midi_encoder;

  localparam int NCFG = 3;
  localparam bit CFG_RS [NCFG] = '{1'b1, 1'b1, 1'b0};
  localparam int CFG_TO [NCFG] = '{10, 0, 10};
  localparam bit CFG_NV [NCFG] = '{1'b0, 1'b1, 1'b0};

  logic       CLOCK_25 = 1'b0;
  logic       iRST, ev_valid, tx_ready;
  logic [2:0] ev_type;
  logic [3:0] ev_chan;
  logic [7:0] ev_d1, ev_d2;
  int         cur;

  logic       ev_ready_a [NCFG];
  logic       tx_valid_a [NCFG];
  logic       ev_err_a   [NCFG];
  logic       busy_a     [NCFG];
  logic [7:0] tx_byte_a  [NCFG];

  always #20 CLOCK_25 = ~CLOCK_25;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    midi_encoder #(
      .RS_EN(CFG_RS[g]), .RS_TIMEOUT(CFG_TO[g]), .NOTEOFF_AS_VEL0(CFG_NV[g]), .T_WIDTH(23)
    ) u_dut (
      .CLOCK_25(CLOCK_25), .iRST(iRST),
      .ev_valid(ev_valid && (cur == g)), .ev_ready(ev_ready_a[g]),
      .ev_type(ev_type), .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2),
      .tx_byte(tx_byte_a[g]), .tx_valid(tx_valid_a[g]), .tx_ready(tx_ready),
      .ev_err(ev_err_a[g]), .busy(busy_a[g])
    );
  end

  // Model state: bytes still owed to the UART (bit 8 marks a status byte),
  // last status sent and cycles elapsed since it was sent.
  logic [8:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] m_last;
  int         age;
  bit         err_pend, acc_seen, rnd_rdy;
  int         rdy_lo;
  int         n_chk, n_err;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    bit         st_sent, acc;
    logic [3:0] hi;
    logic [7:0] st, d1, d2;
    acc_seen = 1'b0;
    if (iRST) begin
      exp_q.delete();
      m_last   = 8'h00;
      age      = 0;
      err_pend = 1'b0;
      return;
    end
    check_eq("ev_err",   int'(ev_err_a[cur]),   int'(err_pend));
    check_eq("ev_ready", int'(ev_ready_a[cur]), int'(exp_q.size() == 0));
    check_eq("tx_valid", int'(tx_valid_a[cur]), int'(exp_q.size() != 0));
    check_eq("busy",     int'(busy_a[cur]),     int'(exp_q.size() != 0));
    acc      = ev_valid && (exp_q.size() == 0);
    acc_seen = acc;
    err_pend = acc && (ev_type > 3'd5);
    st_sent  = 1'b0;
    if (exp_q.size() != 0) begin
      check_eq("tx_byte", int'(tx_byte_a[cur]), int'(exp_q[0][7:0]));
      if (tx_ready) begin
        got_q.push_back(tx_byte_a[cur]);
        if (exp_q[0][8]) begin
          m_last  = exp_q[0][7:0];
          st_sent = 1'b1;
        end
        void'(exp_q.pop_front());
      end
    end
    if (acc && ev_type <= 3'd5) begin
      d1 = ev_d1 % 8'd128;
      d2 = ev_d2 % 8'd128;
      case (ev_type)
        3'd0: begin hi = CFG_NV[cur] ? 4'h9 : 4'h8; if (CFG_NV[cur]) d2 = 8'h00; end
        3'd1: hi = 4'h9;
        3'd2: hi = 4'hB;
        3'd3: hi = 4'hC;
        3'd4: hi = 4'hE;
        default: begin hi = 4'hB; d1 = 8'h7B; d2 = 8'h00; end
      endcase
      st = {hi, ev_chan};
      if (!(CFG_RS[cur] && m_last == st && !(CFG_TO[cur] != 0 && age >= CFG_TO[cur])))
        exp_q.push_back({1'b1, st});
      exp_q.push_back({1'b0, d1});
      if (ev_type != 3'd3) exp_q.push_back({1'b0, d2});
    end
    if (st_sent) age = 0;
    else if (age < 1000000) age++;
  endtask

  task automatic step();
    @(negedge CLOCK_25);
    monitor();
    @(posedge CLOCK_25);
    #1;
    if (rdy_lo > 0) begin
      tx_ready = 1'b0;
      rdy_lo--;
    end else begin
      tx_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic send(input logic [2:0] t, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    bit done;
    done = 1'b0;
    ev_type = t; ev_chan = c; ev_d1 = a; ev_d2 = b;
    ev_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = acc_seen;
    end
    ev_valid = 1'b0;
    if (!done) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      done = (exp_q.size() == 0);
    end
    if (!done) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic expect_bytes(input string tag, input int n, input logic [23:0] v);
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size())
        check_eq($sformatf("%s_b%0d", tag, i), int'(got_q[i]), int'(v[8*(n-1-i) +: 8]));
    got_q.delete();
  endtask

  task automatic do_reset();
    ev_valid = 1'b0;
    iRST = 1'b1;
    step();
    step();
    iRST = 1'b0;
    got_q.delete();
    check_eq("rst_ev_ready", int'(ev_ready_a[cur]), 1);
    check_eq("rst_tx_valid", int'(tx_valid_a[cur]), 0);
    check_eq("rst_tx_byte",  int'(tx_byte_a[cur]),  0);
    check_eq("rst_ev_err",   int'(ev_err_a[cur]),   0);
    check_eq("rst_busy",     int'(busy_a[cur]),     0);
  endtask

  task automatic rand_phase(input int n);
    logic [2:0] t;
    rnd_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      t = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      send(t, 4'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 14)) step();
    end
    rnd_rdy = 1'b0;
    repeat (2) step();
    got_q.delete();
  endtask

  initial begin
    n_chk = 0; n_err = 0; cur = 0;
    iRST = 1'b1; ev_valid = 1'b0; tx_ready = 1'b1;
    ev_type = '0; ev_chan = '0; ev_d1 = '0; ev_d2 = '0;
    m_last = '0; age = 0; err_pend = 1'b0; acc_seen = 1'b0; rnd_rdy = 1'b0; rdy_lo = 0;

    // Running status on, 10-cycle refresh, note-off sent as 8n
    do_reset();
    send(3'd1, 4'd0, 8'h3C, 8'h64); wait_idle(); expect_bytes("note_on",   3, 24'h903C64);
    send(3'd1, 4'd0, 8'h40, 8'h7F); wait_idle(); expect_bytes("rs_reuse",  2, 24'h00407F);
    send(3'd2, 4'd0, 8'h07, 8'h50); wait_idle(); expect_bytes("cc",        3, 24'hB00750);
    send(3'd1, 4'd2, 8'h3C, 8'h64); wait_idle(); expect_bytes("on_ch2",    3, 24'h923C64);
    send(3'd0, 4'd2, 8'h3C, 8'h40); wait_idle(); expect_bytes("off_8n",    3, 24'h823C40);
    send(3'd3, 4'd5, 8'h8A, 8'h00); wait_idle(); expect_bytes("prog",      2, 24'h00C50A);
    send(3'd4, 4'd5, 8'h00, 8'h40); wait_idle(); expect_bytes("bend",      3, 24'hE50040);
    send(3'd5, 4'd5, 8'h12, 8'h34); wait_idle(); expect_bytes("all_off",   3, 24'hB57B00);
    send(3'd1, 4'd1, 8'h3C, 8'h64); wait_idle(); expect_bytes("to_first",  3, 24'h913C64);
    send(3'd1, 4'd1, 8'h3C, 8'h64); wait_idle(); expect_bytes("to_quick",  2, 24'h003C64);
    repeat (10) step();
    send(3'd1, 4'd1, 8'h3C, 8'h64); wait_idle(); expect_bytes("to_expire", 3, 24'h913C64);
    send(3'd7, 4'd3, 8'h11, 8'h22); wait_idle(); step(); expect_bytes("invalid", 0, 24'h0);

    do_reset();
    send(3'd1, 4'd0, 8'h3C, 8'h64);
    rdy_lo = 5;
    wait_idle(); expect_bytes("stall", 3, 24'h903C64);
    send(3'd1, 4'd0, 8'h3C, 8'h64);
    rdy_lo = 3;
    step();
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    check_eq("midrst_tx_valid", int'(tx_valid_a[cur]), 0);
    got_q.delete();
    send(3'd1, 4'd0, 8'h3C, 8'h64); wait_idle(); expect_bytes("after_rst", 3, 24'h903C64);
    rand_phase(120);

    // Note-off as velocity 0, running status never expires
    cur = 1;
    do_reset();
    send(3'd1, 4'd2, 8'h3C, 8'h64); wait_idle(); expect_bytes("nv_on",   3, 24'h923C64);
    send(3'd0, 4'd2, 8'h3C, 8'h40); wait_idle(); expect_bytes("nv_off",  2, 24'h003C00);
    repeat (30) step();
    send(3'd1, 4'd2, 8'h3C, 8'h64); wait_idle(); expect_bytes("nv_keep", 2, 24'h003C64);
    rand_phase(120);

    // Running status disabled
    cur = 2;
    do_reset();
    send(3'd1, 4'd0, 8'h3C, 8'h64); wait_idle(); expect_bytes("nors_1", 3, 24'h903C64);
    send(3'd1, 4'd0, 8'h3C, 8'h64); wait_idle(); expect_bytes("nors_2", 3, 24'h903C64);
    rand_phase(120);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
- Transmit-side counterpart of the MIDI receive/decode path.
- Accepts one channel-voice event per handshake from the synth engine or control logic and serialises it into the MIDI byte stream for the UART transmitter.
- Applies running status with a timed refresh.
- Optionally converts note-off events into note-on with velocity 0.

Parameters:
- RS_EN, 1, 1 = enable running status (omit status byte when it equals the last status byte sent).
- RS_TIMEOUT, 6250000, cycles of no status byte sent after which running status is invalidated (250 ms at 25 MHz); 0 = never invalidate.
- NOTEOFF_AS_VEL0, 0, 1 = encode note-off as status 9n, key, velocity 00.
- T_WIDTH, 23, width of the running-status timer (must hold RS_TIMEOUT).

Ports:
- CLOCK_25  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  encoder can accept an event.
- ev_type  in  3  0 note-off, 1 note-on, 2 control change, 3 program change, 4 pitch bend, 5 all-notes-off, 6/7 invalid.
- ev_chan  in  4  MIDI channel n.
- ev_d1  in  8  key / controller / program / pitch LSB.
- ev_d2  in  8  velocity / value / pitch MSB.
- tx_byte  out  8  byte to UART TX.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART TX accepts byte.
- ev_err  out  1  one-cycle pulse when an invalid ev_type is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - ev_ready=1, tx_valid=0, tx_byte=0, ev_err=0, busy=0.
  - FSM=IDLE, last_status=0 (0 = no valid running status), timer=0.
- Event acceptance:
  - An event is accepted on ev_valid&&ev_ready.
  - ev_ready is 1 only in IDLE.
  - On acceptance, the type, channel, d1 and d2 are latched. Data bytes are masked to [6:0] (bit 7 forced 0).
- Status and data mapping:
  - Status is {hi,ev_chan}, where hi = 8,9,B,C,E for types 0..4, and B for type 5.
  - Type 5 emits data 7B, 00.
  - Type 0 with NOTEOFF_AS_VEL0=1: status hi=9, d2 forced to 00.
  - Data bytes per type: types 0,1,2,4,5 send 2 bytes; type 3 sends 1 byte.
- Invalid type (6/7):
  - Accepted, ev_err=1 the next cycle, nothing sent.
  - FSM stays in IDLE; last_status and timer are unchanged.
- FSM states: IDLE, STATUS, DATA1, DATA2.
  - IDLE→STATUS if !(RS_EN && status==last_status); otherwise IDLE→DATA1.
  - STATUS→DATA1, DATA1→DATA2 (or →IDLE if 1 data byte), DATA2→IDLE. Each transition happens on the cycle tx_valid&&tx_ready.
- Output timing:
  - tx_valid is asserted the cycle after acceptance.
  - tx_byte is held stable while tx_valid=1 and !tx_ready.
  - tx_valid deasserts the cycle after the final byte transfers, and ev_ready returns in that same cycle.
  - Best case: a 3-byte event occupies 4 cycles from acceptance to ev_ready.
- Running status:
  - last_status is updated to the status value when the status byte transfers.
  - timer clears to 0 on every status byte transfer; otherwise it increments, saturating at RS_TIMEOUT.
  - When timer==RS_TIMEOUT and RS_TIMEOUT!=0, last_status is set to 0.
  - RS_EN=0: the status byte is always sent.
- Stall: tx_ready low for any length leaves state, tx_byte and the latched event untouched. No byte is skipped or duplicated.
- Reset mid-event: the partial message is abandoned, tx_valid drops in the reset cycle, and last_status clears, so the next event always carries a status byte.

Test Plan:
- Note-on ch0 key 3C vel 64, tx_ready=1 → bytes 90 3C 64; ev_ready low 3 cycles, high on the 4th; last_status=90.
- Second note-on ch0 key 40 vel 7F (RS_EN=1) → bytes 40 7F only. Then CC ch0 ctrl 07 val 50 → B0 07 50.
- NOTEOFF_AS_VEL0=1, note-off ch2 key 3C vel 40 after a note-on on ch2 → 3C 00 (no status); with NOTEOFF_AS_VEL0=0 → 82 3C 40.
- Program change ch5 prog 8A, then pitch bend ch5 LSB 00 MSB 40 → C5 0A, E5 00 40 (bit 7 masked); all-notes-off ch5 → B5 7B 00.
- RS_TIMEOUT=10: send 91 3C 64, idle 10 cycles, repeat the same event → status 91 re-sent. ev_type=7 → ev_err pulse, no tx_valid.
- tx_ready held low 5 cycles during DATA1 of 90 3C 64 → tx_byte=3C stable throughout, no drop or duplicate. iRST asserted in DATA1 → tx_valid=0, the next 90 event sends the status byte.
